// File: rtl/ss_master.sv
// ss_master: data-stack master that keeps TOS locally and sequences PUSH/POP on the slave stack.
// Build option STACK_ALU_EN enables the ADD/SUB/AND/XOR opcodes (8-11); without it they raise err.
module ss_master #(
    parameter int DEPTH = 16,
    parameter int DSZ   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_op,
    input  logic [DSZ-1:0]             cmd_lit,
    output logic [DSZ-1:0]             tos,
    output logic [$clog2(DEPTH+2)-1:0] depth,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 ss_op,
    output logic [DSZ-1:0]             ss_vi,
    input  logic [DSZ-1:0]             ss_s0
);
    // state  | meaning
    // IDLE   | ready for a command; single-cycle ops complete here
    // SWAP2  | old NOS held in t0; push TOS and take t0 as new TOS
    // ROT2   | b held in t0; pop a into t1
    // ROT3   | push b back onto the slave
    // ROT4   | push c, take a as new TOS

    localparam int DW = $clog2(DEPTH + 2);
    localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH + 1);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_DROP = 4'd2;
    localparam logic [3:0] OP_DUP  = 4'd3;
    localparam logic [3:0] OP_SWAP = 4'd4;
    localparam logic [3:0] OP_OVER = 4'd5;
    localparam logic [3:0] OP_ROT  = 4'd6;
`ifdef STACK_ALU_EN
    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_SUB  = 4'd9;
    localparam logic [3:0] OP_AND  = 4'd10;
    localparam logic [3:0] OP_XOR  = 4'd11;
`endif

    localparam logic [1:0] SS_NOP  = 2'd0;
    localparam logic [1:0] SS_PUSH = 2'd1;
    localparam logic [1:0] SS_POP  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SWAP2,
        S_ROT2,
        S_ROT3,
        S_ROT4
    } state_t;

    state_t         state, state_nxt;
    logic [DSZ-1:0] tos_nxt;
    logic [DW-1:0]  depth_nxt;
    logic [DSZ-1:0] t0, t0_nxt;
    logic [DSZ-1:0] t1, t1_nxt;

    logic           accept;
    logic           op_known;
    logic           op_grow;
    logic [DW-1:0]  min_depth;
    logic           op_bad;

    assign cmd_ready = en & (state == S_IDLE);
    assign accept    = cmd_valid & cmd_ready;

`ifdef STACK_ALU_EN
    logic [DSZ-1:0] alu_res;

    always_comb begin
        case (cmd_op)
            OP_ADD:  alu_res = ss_s0 + tos;
            OP_SUB:  alu_res = ss_s0 - tos;
            OP_AND:  alu_res = ss_s0 & tos;
            default: alu_res = ss_s0 ^ tos;
        endcase
    end
`endif

    // Legality: minimum depth per opcode, and growing ops need a free slave cell.
    always_comb begin
        op_known  = 1'b1;
        op_grow   = 1'b0;
        min_depth = '0;
        case (cmd_op)
            OP_NOP:  ;
            OP_PUSH: op_grow = 1'b1;
            OP_DROP: min_depth = DW'(1);
            OP_DUP: begin
                min_depth = DW'(1);
                op_grow   = 1'b1;
            end
            OP_SWAP: min_depth = DW'(2);
            OP_OVER: begin
                min_depth = DW'(2);
                op_grow   = 1'b1;
            end
            OP_ROT:  min_depth = DW'(3);
`ifdef STACK_ALU_EN
            OP_ADD, OP_SUB, OP_AND, OP_XOR: min_depth = DW'(2);
`endif
            default: op_known = 1'b0;
        endcase
        op_bad = !op_known || (depth < min_depth) || (op_grow && (depth == DEPTH_FULL));
    end

    always_comb begin
        state_nxt = state;
        tos_nxt   = tos;
        depth_nxt = depth;
        t0_nxt    = t0;
        t1_nxt    = t1;
        ss_op     = SS_NOP;
        ss_vi     = '0;
        done      = 1'b0;
        err       = 1'b0;
        if (en) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op_bad) begin
                            err = 1'b1;
                        end else begin
                            case (cmd_op)
                                OP_PUSH: begin
                                    if (depth != '0) begin
                                        ss_op = SS_PUSH;
                                        ss_vi = tos;
                                    end
                                    tos_nxt   = cmd_lit;
                                    depth_nxt = depth + DW'(1);
                                    done      = 1'b1;
                                end
                                OP_DROP: begin
                                    if (depth > DW'(1)) begin
                                        ss_op   = SS_POP;
                                        tos_nxt = ss_s0;
                                    end else begin
                                        tos_nxt = '0;
                                    end
                                    depth_nxt = depth - DW'(1);
                                    done      = 1'b1;
                                end
                                OP_DUP: begin
                                    ss_op     = SS_PUSH;
                                    ss_vi     = tos;
                                    depth_nxt = depth + DW'(1);
                                    done      = 1'b1;
                                end
                                OP_OVER: begin
                                    ss_op     = SS_PUSH;
                                    ss_vi     = tos;
                                    tos_nxt   = ss_s0;
                                    depth_nxt = depth + DW'(1);
                                    done      = 1'b1;
                                end
                                OP_SWAP: begin
                                    ss_op     = SS_POP;
                                    t0_nxt    = ss_s0;
                                    state_nxt = S_SWAP2;
                                end
                                OP_ROT: begin
                                    ss_op     = SS_POP;
                                    t0_nxt    = ss_s0;
                                    state_nxt = S_ROT2;
                                end
`ifdef STACK_ALU_EN
                                OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                                    ss_op     = SS_POP;
                                    tos_nxt   = alu_res;
                                    depth_nxt = depth - DW'(1);
                                    done      = 1'b1;
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                S_SWAP2: begin
                    ss_op     = SS_PUSH;
                    ss_vi     = tos;
                    tos_nxt   = t0;
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
                S_ROT2: begin
                    ss_op     = SS_POP;
                    t1_nxt    = ss_s0;
                    state_nxt = S_ROT3;
                end
                S_ROT3: begin
                    ss_op     = SS_PUSH;
                    ss_vi     = t0;
                    state_nxt = S_ROT4;
                end
                S_ROT4: begin
                    ss_op     = SS_PUSH;
                    ss_vi     = tos;
                    tos_nxt   = t1;
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            tos   <= '0;
            depth <= '0;
            t0    <= '0;
            t1    <= '0;
        end else begin
            state <= state_nxt;
            tos   <= tos_nxt;
            depth <= depth_nxt;
            t0    <= t0_nxt;
            t1    <= t1_nxt;
        end
    end

endmodule

// File: tb/tb_ss_master.sv
// tb_ss_master: random and directed commands for ss_master, checked every cycle against a
// command-level stack model; a simple array stack stands in for the slave.
module tb_ss_master;
    localparam int DEPTH = 16;
    localparam int DSZ   = 32;
    localparam int DW    = $clog2(DEPTH + 2);

    typedef logic [DSZ-1:0] cell_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_op = 4'd0;
    cell_t         cmd_lit = '0;
    cell_t         tos;
    logic [DW-1:0] depth;
    logic          done, err;
    logic [1:0]    ss_op;
    cell_t         ss_vi, ss_s0;

    int total = 0;
    int bad   = 0;
    bit rand_en = 1'b0;

    ss_master #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_lit(cmd_lit),
        .tos(tos), .depth(depth), .done(done), .err(err),
        .ss_op(ss_op), .ss_vi(ss_vi), .ss_s0(ss_s0)
    );

    always #5 clk = ~clk;

    // Slave stack: plain array with a count, same reset net as the DUT.
    cell_t smem [DEPTH];
    int    sp;
    always @(posedge clk or posedge rst) begin
        if (rst) sp <= 0;
        else if (ss_op == 2'd1 && sp < DEPTH) begin
            smem[sp] <= ss_vi;
            sp <= sp + 1;
        end else if (ss_op == 2'd2 && sp > 0) sp <= sp - 1;
    end
    assign ss_s0 = (sp > 0) ? smem[sp-1] : '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- command-level reference model ----------------
    cell_t stk[$];
    cell_t pend[$];
    int    busy = 0;

    function automatic bit legal(input logic [3:0] op, input int d);
        case (op)
            4'd0: return 1'b1;
            4'd1: return d <= DEPTH;
            4'd2: return d >= 1;
            4'd3: return d >= 1 && d <= DEPTH;
            4'd4: return d >= 2;
            4'd5: return d >= 2 && d <= DEPTH;
            4'd6: return d >= 3;
`ifdef STACK_ALU_EN
            4'd8, 4'd9, 4'd10, 4'd11: return d >= 2;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] op);
        if (op == 4'd4) return 2;
        if (op == 4'd6) return 4;
        return 1;
    endfunction

    function automatic void compute(input logic [3:0] op, input cell_t lit);
        cell_t a, b, c;
        pend = stk;
        case (op)
            4'd1: pend.push_back(lit);
            4'd2: void'(pend.pop_back());
            4'd3: pend.push_back(pend[pend.size()-1]);
            4'd5: pend.push_back(pend[pend.size()-2]);
            4'd4: begin
                b = pend.pop_back(); a = pend.pop_back();
                pend.push_back(b); pend.push_back(a);
            end
            4'd6: begin
                c = pend.pop_back(); b = pend.pop_back(); a = pend.pop_back();
                pend.push_back(b); pend.push_back(c); pend.push_back(a);
            end
            4'd8, 4'd9, 4'd10, 4'd11: begin
                b = pend.pop_back(); a = pend.pop_back();
                if (op == 4'd8) pend.push_back(a + b);
                else if (op == 4'd9) pend.push_back(a - b);
                else if (op == 4'd10) pend.push_back(a & b);
                else pend.push_back(a ^ b);
            end
            default: ;
        endcase
    endfunction

    cell_t e_tos;
    int    e_dep;
    bit    e_rdy, e_done, e_err, e_quiet;

    // Compare on the falling edge, then advance the model over the coming rising edge.
    always @(negedge clk) begin
        if (rst) begin
            stk.delete();
            pend.delete();
            busy = 0;
        end else begin
            e_dep   = stk.size();
            e_tos   = (e_dep > 0) ? stk[e_dep-1] : '0;
            e_rdy   = en && busy == 0;
            e_done  = en && busy == 1;
            e_err   = 1'b0;
            e_quiet = !en;
            if (e_rdy && cmd_valid) begin
                if (!legal(cmd_op, e_dep)) begin
                    e_err   = 1'b1;
                    e_quiet = 1'b1;
                end else if (cmd_op == 4'd0) e_quiet = 1'b1;
                else if (latency(cmd_op) == 1) e_done = 1'b1;
            end
            chk("tos", tos, e_tos);
            chk("depth", depth, e_dep);
            chk("cmd_ready", cmd_ready, e_rdy);
            chk("done", done, e_done);
            chk("err", err, e_err);
            if (e_quiet) chk("ss_op_quiet", ss_op, 0);
            if (busy == 0) chk("slave_count", sp, (e_dep > 0) ? e_dep - 1 : 0);
            if (busy == 0 && e_dep >= 2) chk("slave_nos", ss_s0, stk[e_dep-2]);
            if (ss_op == 2'd1) chk("slave_not_full", sp < DEPTH, 1);
            if (ss_op == 2'd2) chk("slave_not_empty", sp > 0, 1);
            if (en) begin
                if (busy > 0) begin
                    busy--;
                    if (busy == 0) stk = pend;
                end else if (cmd_valid && legal(cmd_op, e_dep)) begin
                    compute(cmd_op, cmd_lit);
                    busy = latency(cmd_op) - 1;
                    if (busy == 0) stk = pend;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic  s_ready, s_done, s_err;
    logic [1:0] s_op;
    cell_t s_vi;

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_en) en = ($urandom_range(0, 7) != 0);
    endtask

    task automatic issue(input logic [3:0] op, input cell_t lit);
        bit got = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_lit   = lit;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            s_ready = cmd_ready; s_done = done; s_err = err; s_op = ss_op; s_vi = ss_vi;
            step();
            got = s_ready;
        end
        cmd_valid = 1'b0;
        chk("accept_in_time", got, 1);
    endtask

    task automatic wait_idle(output int n, output bit dl);
        bit seen = 1'b0;
        n  = 0;
        dl = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (cmd_ready) seen = 1'b1;
            else begin
                n++;
                dl = done;
            end
            step();
        end
        chk("idle_in_time", seen, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int n_busy;
    bit d_last;
    int r;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tos", tos, 0);
        chk("rst_depth", depth, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_ss", {ss_op, ss_vi}, 0);
        rst = 1'b0;

        // 15 back-to-back pushes
        for (int i = 0; i < 15; i++) begin
            issue(4'd1, cell_t'(1000 + i));
            chk("push_done", s_done, 1);
            if (i > 0) begin
                chk("push_ss_op", s_op, 1);
                chk("push_ss_vi", s_vi, 1000 + i - 1);
            end
        end
        chk("push_tos", tos, 1014);
        chk("push_depth", depth, 15);

        // SWAP then ROT from [1,2,3]
        do_reset();
        issue(4'd1, 1); issue(4'd1, 2); issue(4'd1, 3);
        issue(4'd4, 0);
        wait_idle(n_busy, d_last);
        chk("swap_busy", n_busy, 1);
        chk("swap_done", d_last, 1);
        chk("swap_tos", tos, 2);
        chk("swap_nos", ss_s0, 3);
        issue(4'd6, 0);
        wait_idle(n_busy, d_last);
        chk("rot_busy", n_busy, 3);
        chk("rot_done", d_last, 1);
        chk("rot_tos", tos, 1);
        chk("rot_nos", ss_s0, 2);
        issue(4'd2, 0);
        chk("rot_after_drop", tos, 2);

        // underflow cases from [5]
        do_reset();
        issue(4'd1, 5);
        issue(4'd5, 0);
        chk("over_err", {s_err, s_done}, 2'b10);
        chk("over_depth", depth, 1);
        issue(4'd3, 0);
        chk("dup_tos_depth", {tos, 32'(depth)}, {32'd5, 32'd2});
        issue(4'd2, 0); issue(4'd2, 0);
        chk("drop_empty", {tos, 32'(depth)}, 0);
        issue(4'd2, 0);
        chk("drop_underflow_err", s_err, 1);

        // overflow at DEPTH+1
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) issue(4'd1, cell_t'(i));
        chk("full_depth", depth, DEPTH + 1);
        issue(4'd1, 99);
        chk("full_push_err", {s_err, s_op}, 3'b100);
        issue(4'd3, 0);
        chk("full_dup_err", {s_err, s_op}, 3'b100);
        issue(4'd2, 0);
        chk("full_drop", {s_done, s_op}, 3'b110);
        chk("full_drop_tos", tos, DEPTH - 1);

        // en low in ROT2 pauses the sequence
        do_reset();
        issue(4'd1, 1); issue(4'd1, 2); issue(4'd1, 3);
        issue(4'd6, 0);
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("pause_quiet", {ss_op, cmd_ready, done}, 0);
            step();
        end
        en = 1'b1;
        wait_idle(n_busy, d_last);
        chk("resume_busy", n_busy, 3);
        chk("resume_tos", tos, 1);

        // reset during ROT3
        do_reset();
        issue(4'd1, 10); issue(4'd1, 20); issue(4'd1, 30);
        issue(4'd6, 0);
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_tos_depth", {tos, 32'(depth)}, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", cmd_ready, 1);
        step();

`ifdef STACK_ALU_EN
        do_reset();
        issue(4'd1, 7); issue(4'd1, 3);
        issue(4'd9, 0);
        chk("sub_tos", tos, 4);
        chk("sub_depth", depth, 1);
        do_reset();
        issue(4'd1, 0); issue(4'd1, 1);
        issue(4'd9, 0);
        chk("sub_wrap", tos, 32'hFFFF_FFFF);
`else
        do_reset();
        issue(4'd1, 1); issue(4'd1, 2);
        issue(4'd8, 0);
        chk("add_illegal_err", s_err, 1);
        chk("add_illegal_state", {tos, 32'(depth)}, {32'd2, 32'd2});
`endif

        // random commands with random enable
        do_reset();
        rand_en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30) issue(4'd1, $urandom);
            else if (r < 42) issue(4'd2, 0);
            else issue(4'($urandom_range(0, 15)), $urandom);
        end
        rand_en = 1'b0;
        en = 1'b1;
        wait_idle(n_busy, d_last);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
